// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product MAC controller.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // DRAIN must cover the valid pipe so the last product reaches the accumulator.
  localparam int DRAIN_CYCLES = 2;
  localparam int VALID_DEPTH  = DRAIN_CYCLES;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

endpackage

// File: rtl/valid_pipe.sv
// Delay line for the issue-valid strobe; o_taps[k] is the input delayed k+1 cycles.
module valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic [DEPTH-1:0] o_taps
);

  logic [DEPTH-1:0] r_pipe;
  logic [DEPTH-1:0] w_shift_in;

  assign w_shift_in[0] = i_valid;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign w_shift_in[gi] = r_pipe[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= w_shift_in;
    end
  end

  assign o_taps = r_pipe;

endmodule

// File: rtl/mac_ctrl.sv
// Sequencer for one dot-product job: clears the accumulator, streams operand
// addresses, and steers product/accumulator enables through a valid pipe.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              mul_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t                 r_state, w_state;
  logic [ADDR_W-1:0]      r_addr, w_addr;
  logic [LEN_W-1:0]       r_len, w_len;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt, w_drain_cnt;
  logic                   w_issue;
  logic                   w_last;
  logic [VALID_DEPTH-1:0] w_taps;

  // Widened compare so a full 2^ADDR_W job ends at the top address without wrapping.
  assign w_last = (LEN_W'(r_addr) + LEN_W'(1)) == r_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_len       <= w_len;
      r_drain_cnt <= w_drain_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_len       = r_len;
    w_drain_cnt = r_drain_cnt;
    w_issue     = 1'b0;
    acc_clr     = 1'b0;
    res_valid   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_len   = (len > MAX_LEN) ? MAX_LEN : len;
          w_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_clr     = 1'b1;
        w_drain_cnt = '0;
        // An empty job leaves addr on its previously issued value.
        if (r_len != '0) begin
          w_addr  = '0;
          w_state = ST_FETCH;
        end else begin
          w_state = ST_DRAIN;
        end
      end
      ST_FETCH: begin
        w_issue = 1'b1;
        if (w_last) begin
          w_state = ST_DRAIN;
        end else begin
          w_addr = r_addr + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
          w_state = ST_DONE;
        end else begin
          w_drain_cnt = r_drain_cnt + DRAIN_CNT_W'(1);
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          done    = 1'b1;
          w_state = ST_IDLE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  valid_pipe #(
    .DEPTH (VALID_DEPTH)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_issue),
    .o_taps  (w_taps)
  );

  assign addr   = r_addr;
  assign mul_en = w_taps[0];
  assign acc_en = w_taps[VALID_DEPTH-1];

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench: mac_ctrl driving two operand ROMs, a product register and an accumulator.
module tb_mac_ctrl;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              res_ready = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              mul_en, acc_clr, acc_en, res_valid, busy, done;

  always #5 clk = ~clk;

  mac_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .addr      (addr),
    .mul_en    (mul_en),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done)
  );

  // Datapath around the controller: synchronous ROMs, product and accumulator registers.
  logic [7:0]  rom_a [256];
  logic [7:0]  rom_b [256];
  logic [7:0]  qa, qb;
  logic [15:0] prod;
  logic [31:0] acc;

  always @(posedge clk) begin
    qa <= rom_a[addr];
    qb <= rom_b[addr];
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= 16'(qa) * 16'(qb);
      if (acc_clr) acc <= '0;
      else if (acc_en) acc <= acc + 32'(prod);
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_roms(input int mode);
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = (mode == 0) ? 8'd1 : 8'd0;
      rom_b[i] = (mode == 0) ? 8'd1 : 8'd0;
    end
  endtask

  // Runs one job; expectations come from the cycle table (start sampled at cycle 0).
  task automatic run_job(input string name, input int n, input int d, input bit pulse,
                         input logic [31:0] exp_res);
    int ne;
    int e_clr, e_addr, e_mul, e_acc, e_vld, e_done, e_busy, e_res;
    int n_mul, n_acc, n_done;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] final_res;
    ne = (n > 256) ? 256 : n;
    {e_clr, e_addr, e_mul, e_acc, e_vld, e_done, e_busy, e_res} = '0;
    {n_mul, n_acc, n_done} = '0;
    final_res = 'x;
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(n);
    res_ready = 1'b0;
    for (int c = 1; c <= ne + 6 + d; c++) begin
      @(negedge clk);
      start = pulse && (c == 2 || (c >= ne + 4 && c <= ne + 4 + d));
      res_ready = (c >= ne + 4 + d);
      #1;
      if (c >= 2 && c <= ne + 1) exp_addr = ADDR_W'(c - 2);
      else if (c > ne + 1 && ne > 0) exp_addr = ADDR_W'(ne - 1);
      else exp_addr = last_addr;
      if (acc_clr !== 1'(c == 1)) e_clr++;
      if (addr !== exp_addr) e_addr++;
      if (mul_en !== 1'(c >= 3 && c <= ne + 2)) e_mul++;
      if (acc_en !== 1'(c >= 4 && c <= ne + 3)) e_acc++;
      if (res_valid !== 1'(c >= ne + 4 && c <= ne + 4 + d)) e_vld++;
      if (done !== 1'(c == ne + 4 + d)) e_done++;
      if (busy !== 1'(c <= ne + 4 + d)) e_busy++;
      if (c >= ne + 4 && c <= ne + 4 + d && acc !== exp_res) e_res++;
      if (mul_en === 1'b1) n_mul++;
      if (acc_en === 1'b1) n_acc++;
      if (done === 1'b1) begin
        n_done++;
        final_res = acc;
      end
    end
    start = 1'b0;
    res_ready = 1'b0;
    if (ne > 0) last_addr = ADDR_W'(ne - 1);
    check({name, " acc_clr"}, e_clr, 0);
    check({name, " addr"}, e_addr, 0);
    check({name, " mul_en"}, e_mul, 0);
    check({name, " acc_en"}, e_acc, 0);
    check({name, " res_valid"}, e_vld, 0);
    check({name, " done"}, e_done, 0);
    check({name, " busy"}, e_busy, 0);
    check({name, " result_stable"}, e_res, 0);
    check({name, " mul_cnt"}, n_mul, ne);
    check({name, " acc_cnt"}, n_acc, ne);
    check({name, " done_cnt"}, n_done, 1);
    check({name, " result"}, final_res, exp_res);
    $display("job %s len=%0d result=%0d expected=%0d", name, n, final_res, exp_res);
  endtask

  int n_stray;

  initial begin
    fill_roms(1);
    start = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst mul_en", mul_en, 0);
    check("rst acc_en", acc_en, 0);
    check("rst acc_clr", acc_clr, 0);
    check("rst res_valid", res_valid, 0);
    check("rst done", done, 0);
    check("rst addr", addr, 0);
    $display("reset checked: busy=%0d addr=%0d", busy, addr);
    start = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b1;

    rom_a[0] = 8'd1; rom_a[1] = 8'd2; rom_a[2] = 8'd3; rom_a[3] = 8'd4;
    rom_b[0] = 8'd5; rom_b[1] = 8'd6; rom_b[2] = 8'd7; rom_b[3] = 8'd8;
    run_job("len4", 4, 0, 1'b0, 32'd70);
    run_job("len0", 0, 0, 1'b0, 32'd0);

    fill_roms(0);
    run_job("len256", 256, 0, 1'b0, 32'd256);
    run_job("len300", 300, 0, 1'b0, 32'd256);

    rom_a[0] = 8'd2;  rom_a[1] = 8'd3;  rom_a[2] = 8'd4;
    rom_b[0] = 8'd10; rom_b[1] = 8'd20; rom_b[2] = 8'd30;
    run_job("hold10", 3, 10, 1'b1, 32'd200);

    // Abort a len=8 job with reset in cycle 5, then confirm nothing leaks out.
    @(negedge clk);
    start = 1'b1;
    len = LEN_W'(8);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort busy", busy, 0);
    check("abort mul_en", mul_en, 0);
    check("abort acc_en", acc_en, 0);
    check("abort addr", addr, 0);
    rst_n = 1'b1;
    n_stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (mul_en !== 1'b0 || acc_en !== 1'b0 || busy !== 1'b0) n_stray++;
    end
    check("abort quiet", n_stray, 0);
    $display("abort of len=8 job checked");
    last_addr = '0;

    rom_a[0] = 8'd3; rom_a[1] = 8'd4;
    rom_b[0] = 8'd5; rom_b[1] = 8'd6;
    run_job("after_rst", 2, 0, 1'b0, 32'd39);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
